adder51_rr_arbiter: RTL and testbench
=====================================

Name: adder51_rr_arbiter

Overview:
- Shares one combinational 51+13-bit unsigned adder (51-bit A, 13-bit B zero-extended, 52-bit Sum) among NUM_REQ requesters.
- Round-robin grant, valid/ready handshake per requester, one-entry registered result buffer with requester ID.
- Sits between the mantissa/accumulate stages and the single shared adder instance. The adder is external: this block drives its operands and samples its sum.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  input  NUM_REQ*51  packed A operands; requester i at bits [i*51 +: 51].
- req_b  input  NUM_REQ*13  packed B operands; requester i at bits [i*13 +: 13].
- add_a  output  51  operand A to shared adder.
- add_b  output  13  operand B to shared adder.
- add_sum  input  52  combinational sum from shared adder.
- resp_valid  output  1  result buffer holds a result.
- resp_ready  input  1  consumer accepts result.
- resp_sum  output  52  registered sum.
- resp_id  output  ID_W  index of the requester that produced resp_sum.

Behaviour:
- Reset (async, rst=1):
  - resp_valid=0, resp_sum=0, resp_id=0.
  - Round-robin pointer rr_ptr=0, state=EMPTY.
  - req_ready=0 while rst is asserted.
- States:
  - EMPTY: buffer free.
  - FULL: buffer holds an unconsumed result.
- can_accept = (state==EMPTY) | (resp_valid & resp_ready).
- Grant selection, combinational:
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ; the first set bit wins (gnt).
  - With no valid request there is no grant.
- Outputs toward requesters and adder:
  - req_ready[gnt] = can_accept; all other req_ready bits = 0.
  - req_ready never depends on req_a or req_b.
  - add_a/add_b = operands of gnt.
  - With no grant, add_a/add_b = requester rr_ptr's operands; these are don't-care, not checked.
- Transfer: a request transfers when req_valid[gnt] & req_ready[gnt].
  - On the transfer edge: resp_sum <= add_sum, resp_id <= gnt, resp_valid <= 1, state <= FULL.
  - rr_ptr <= (gnt+1) mod NUM_REQ.
- Latency: exactly 1 cycle from transfer to resp_valid=1. Throughput is 1 result/cycle when resp_ready is held high.
- Drain without refill: resp_valid & resp_ready with no new transfer gives resp_valid <= 0 and state <= EMPTY. resp_sum/resp_id hold their last values.
- Simultaneous drain and accept in the same cycle: the buffer is overwritten with the new result and resp_valid stays 1. No bubble.
- Backpressure: when state==FULL and resp_ready=0:
  - All req_ready=0.
  - resp_sum, resp_id and resp_valid are held stable.
  - rr_ptr is unchanged.
- Fairness:
  - rr_ptr advances only on a transfer.
  - A continuously valid requester is granted within NUM_REQ transfers.
- Arithmetic:
  - The block does no arithmetic itself.
  - add_sum is the full 52-bit unsigned sum; bit 51 is the carry out. It is registered unmodified.
- Requester protocol: a requester must hold req_valid and operands stable until its req_ready. Dropping req_valid early is legal and simply removes it from arbitration.
- Reset mid-operation: the buffered result is discarded, resp_valid=0 immediately, and rr_ptr returns to 0.

Optional Feature:
- Macro: ADDER51_ARB_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt[15:0], reset 0.
  - It increments on each cycle where |req_valid=1 and no transfer occurs, and saturates at 16'hFFFF.
  - Adds input perf_clr, 1 bit, synchronous clear with priority over increment.
- Not defined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Single request: reset, then req_valid=4'b0001, A=51'h7_FFFF_FFFF_FFFF, B=13'h1FFF, resp_ready=1 -> next cycle resp_valid=1, resp_sum=52'h8_0000_0000_1FFE, resp_id=0.
- Round robin: all 4 requesters valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0, one result per cycle, no bubbles.
- Backpressure: req 2 valid with A=100, B=5, resp_ready=0 for 3 cycles ->
  - resp_valid=1 and resp_sum=105 held.
  - req_ready=0 throughout.
  - On resp_ready=1 the next queued request is accepted the same cycle.
- Skip and wrap: rr_ptr=3, req_valid=4'b0101 -> gnt=0, then rr_ptr=1, then gnt=2.
- Async reset mid-FULL: assert rst between clock edges while resp_valid=1 -> resp_valid=0 before the next edge. After release the first grant goes to the lowest valid index.
- PERF_EN: 5 stall cycles under backpressure -> perf_stall_cnt=5. perf_clr -> 0. Force 70000 stalls -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/adder51_rr_arbiter.sv
// Round-robin share of one external 51+13-bit adder; result registered 1 cycle after transfer, req_ready all-low while a result is stalled.
// Optional build macro ADDER51_ARB_PERF_EN adds the perf_stall_cnt/perf_clr stall counter.
module adder51_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*51-1:0] req_a,
  input  logic [NUM_REQ*13-1:0] req_b,
  output logic [50:0]           add_a,
  output logic [12:0]           add_b,
  input  logic [51:0]           add_sum,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [51:0]           resp_sum,
  output logic [ID_W-1:0]       resp_id
`ifdef ADDER51_ARB_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [15:0]           perf_stall_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [51:0]     sum_q, sum_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic            gnt_vld;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W:0]   cand;
  logic            can_accept;
  logic            xfer;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_ptr_q;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!gnt_vld && req_valid[cand[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end

  assign can_accept = (state_q == EMPTY) | resp_ready;
  assign xfer       = gnt_vld & can_accept & ~rst;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Without a grant gnt_idx is rr_ptr, so the adder still sees stable operands.
  assign add_a = req_a[gnt_idx*51 +: 51];
  assign add_b = req_b[gnt_idx*13 +: 13];

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      state_d = FULL;
      sum_d   = add_sum;
      id_d    = gnt_idx;
      if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + 1'b1;
      end
    end else if (state_q == FULL && resp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      sum_q    <= '0;
      id_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign resp_valid = (state_q == FULL);
  assign resp_sum   = sum_q;
  assign resp_id    = id_q;

`ifdef ADDER51_ARB_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
    end else if ((|req_valid) && !xfer && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_adder51_rr_arbiter.sv
// Randomized and directed bench for adder51_rr_arbiter against a transaction-level reference model.
module tb_adder51_rr_arbiter;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*51-1:0]   req_a;
  logic [N*13-1:0]   req_b;
  logic [50:0]       add_a;
  logic [12:0]       add_b;
  logic [51:0]       add_sum;
  logic              resp_valid;
  logic              resp_ready;
  logic [51:0]       resp_sum;
  logic [1:0]        resp_id;
`ifdef ADDER51_ARB_PERF_EN
  logic              perf_clr;
  logic [15:0]       perf_stall_cnt;
  int                m_stall;
`endif

  always #5 clk = ~clk;

  // The shared external adder.
  assign add_sum = {1'b0, add_a} + {39'b0, add_b};

  adder51_rr_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_sum(resp_sum), .resp_id(resp_id)
`ifdef ADDER51_ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Requester-side stimulus and model of the arbiter's observable state.
  logic        pend [N];
  logic [50:0] a_op [N];
  logic [12:0] b_op [N];
  int          m_ptr;
  logic        m_full;
  logic [51:0] m_sum;
  int          m_id;
  logic        rr_en;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = pend[i];
      req_a[i*51 +: 51]    = a_op[i];
      req_b[i*13 +: 13]    = b_op[i];
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_full = 1'b0;
    m_sum  = '0;
    m_id   = 0;
`ifdef ADDER51_ARB_PERF_EN
    m_stall = 0;
`endif
  endtask

  // One clock: drive, check at the falling edge, advance the model, return just after the rising edge.
  task automatic cyc();
    int g;
    logic can, x;
    logic [N-1:0] exp_rdy;
    drive();
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    can = !m_full || resp_ready;
    x = (g >= 0) && can;
    exp_rdy = '0;
    if (x) exp_rdy[g] = 1'b1;
    check_val("req_ready", 64'(req_ready), 64'(exp_rdy));
    check_val("resp_valid", 64'(resp_valid), 64'(m_full));
    if (m_full) begin
      check_val("resp_sum", 64'(resp_sum), 64'(m_sum));
      check_val("resp_id", 64'(resp_id), 64'(m_id));
    end
`ifdef ADDER51_ARB_PERF_EN
    check_val("perf_cnt", 64'(perf_stall_cnt), 64'(m_stall));
    if (perf_clr) m_stall = 0;
    else if ((pend[0] || pend[1] || pend[2] || pend[3]) && !x && m_stall < 65535) m_stall++;
`endif
    if (x) begin
      m_full  = 1'b1;
      m_sum   = 52'(a_op[g]) + 52'(b_op[g]);
      m_id    = g;
      m_ptr   = (g + 1) % N;
      pend[g] = rr_en;
    end else if (m_full && resp_ready) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    resp_ready = 1'b0;
    rr_en = 1'b0;
`ifdef ADDER51_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      a_op[i] = 51'(i + 1);
      b_op[i] = 13'(i);
    end
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_val("rst_resp_sum", 64'(resp_sum), 64'd0);
    check_val("rst_resp_id", 64'(resp_id), 64'd0);
    check_val("rst_req_ready", 64'(req_ready), 64'd0);

    // Single request with maximal carry.
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    pend[0] = 1'b1; a_op[0] = 51'h7_FFFF_FFFF_FFFF; b_op[0] = 13'h1FFF;
    resp_ready = 1'b1;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    check_val("single_valid", 64'(resp_valid), 64'd1);
    check_val("single_sum", 64'(resp_sum), 64'h8_0000_0000_1FFE);
    check_val("single_id", 64'(resp_id), 64'd0);
    cyc();
    check_val("drain_valid", 64'(resp_valid), 64'd0);
    check_val("drain_sum_hold", 64'(resp_sum), 64'h8_0000_0000_1FFE);

    // Continuous round robin over all requesters.
    do_reset();
    rr_en = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cyc();
      check_val("rr_id", 64'(resp_id), 64'(n % N));
      check_val("rr_valid", 64'(resp_valid), 64'd1);
    end
    rr_en = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    cyc();

    // Backpressure with a queued request behind it.
    do_reset();
    pend[2] = 1'b1; a_op[2] = 51'd100; b_op[2] = 13'd5;
    cyc();
    resp_ready = 1'b0;
    pend[0] = 1'b1; a_op[0] = 51'd7; b_op[0] = 13'd8;
    for (int n = 0; n < 3; n++) begin
      drive();
      #1;
      check_val("bp_ready", 64'(req_ready), 64'd0);
      cyc();
      check_val("bp_sum", 64'(resp_sum), 64'd105);
      check_val("bp_valid", 64'(resp_valid), 64'd1);
    end
    resp_ready = 1'b1;
    drive();
    #1;
    check_val("bp_release_ready", 64'(req_ready), 64'b0001);
    cyc();
    check_val("bp_release_sum", 64'(resp_sum), 64'd15);

    // Skip and wrap: ptr is 1 here; go through req 2 to reach ptr 3.
    pend[2] = 1'b1;
    cyc();
    pend[0] = 1'b1; pend[2] = 1'b1;
    cyc();
    check_val("wrap_gnt0", 64'(resp_id), 64'd0);
    cyc();
    check_val("wrap_gnt2", 64'(resp_id), 64'd2);
    cyc();

    // Async reset while a result is held.
    pend[3] = 1'b1;
    resp_ready = 1'b0;
    cyc();
    check_val("pre_arst_valid", 64'(resp_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("arst_valid", 64'(resp_valid), 64'd0);
    check_val("arst_sum", 64'(resp_sum), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    pend[1] = 1'b1; pend[3] = 1'b1;
    cyc();
    check_val("post_arst_id", 64'(resp_id), 64'd1);
    pend[1] = 1'b0; pend[3] = 1'b0;
    cyc();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          a_op[i] = {19'($urandom), 32'($urandom)};
          b_op[i] = 13'($urandom);
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

`ifdef ADDER51_ARB_PERF_EN
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    resp_ready = 1'b1;
    pend[0] = 1'b1;
    cyc();
    resp_ready = 1'b0;
    pend[1] = 1'b1;
    repeat (5) cyc();
    check_val("perf_five", 64'(perf_stall_cnt), 64'd5);
    perf_clr = 1'b1;
    cyc();
    perf_clr = 1'b0;
    check_val("perf_clr", 64'(perf_stall_cnt), 64'd0);
    repeat (70000) @(posedge clk);
    #1;
    check_val("perf_sat", 64'(perf_stall_cnt), 64'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
